// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage MIPS core.
//
// Turns operand dependencies and multi-cycle resource occupancy into per-stage
// stall and flush controls. It works next to the forwarding unit and handles
// the cases where an operand or resource cannot be supplied in time:
// load-use and branch-use hazards, multi-cycle multiply/divide, outstanding
// instruction/data memory handshakes, and squashed fetches still in flight.
//
// Ports
//   clk, reset            core clock, synchronous active-high reset
//   srcaD, srcbD          Decode source register numbers
//   branchD               Decode instruction compares registers in Decode
//   writeregE             Execute destination register
//   regwriteE, memtoregE  Execute writes a register / is a load
//   mdstartE, mdisdivE    Execute holds a mult/div; 1 = divide
//   ireq, idata_ok        fetch request valid / instruction returned
//   dreq, ddata_ok        Memory-stage request valid / data returned
//   exceptionM            exception taken in Memory stage
//   stallF..stallM        hold stage register
//   flushD..flushW        load bubble into stage register
//   mdbusy                multdiv sequencer is busy
//   idiscard              fetch must drop the returning instruction
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] srcaD,
  input  logic [4:0] srcbD,
  input  logic       branchD,
  input  logic [4:0] writeregE,
  input  logic       regwriteE,
  input  logic       memtoregE,
  input  logic       mdstartE,
  input  logic       mdisdivE,
  input  logic       ireq,
  input  logic       idata_ok,
  input  logic       dreq,
  input  logic       ddata_ok,
  input  logic       exceptionM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       mdbusy,
  output logic       idiscard
);

  // The first Execute cycle is spent in idle and the last one at cnt == 0,
  // so the counter is loaded with the occupancy minus two.
  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 2);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 2);

  typedef enum logic {
    MdIdle,
    MdBusy
  } md_state_e;

  typedef enum logic {
    FetchIdle,
    FetchDiscard
  } fetch_state_e;

  md_state_e        r_md_state, w_md_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  fetch_state_e     r_f_state, w_f_state_d;

  logic w_dep;
  logic w_lu;
  logic w_br;
  logic w_mdstall;
  logic w_istall;
  logic w_dstall;

  // --------------------------------------------------------------------------
  // Operand hazards. Register 0 is never a real dependency.
  // --------------------------------------------------------------------------
  always_comb begin
    w_dep = (writeregE != 5'd0) && ((writeregE == srcaD) || (writeregE == srcbD));
    w_lu  = w_dep && regwriteE && memtoregE;
    w_br  = w_dep && regwriteE && branchD;
  end

  // --------------------------------------------------------------------------
  // Multdiv sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_state <= MdIdle;
      r_cnt      <= '0;
    end else begin
      r_md_state <= w_md_state_d;
      r_cnt      <= w_cnt_d;
    end
  end

  always_comb begin
    w_md_state_d = r_md_state;
    w_cnt_d      = r_cnt;
    if (exceptionM) begin
      // The mult/div in Execute is squashed with the rest of the pipeline.
      w_md_state_d = MdIdle;
      w_cnt_d      = '0;
    end else begin
      unique case (r_md_state)
        MdIdle: begin
          if (mdstartE) begin
            w_md_state_d = MdBusy;
            w_cnt_d      = mdisdivE ? DivLoad : MultLoad;
          end
        end
        MdBusy: begin
          // A start seen at cnt == 0 belongs to the departing instruction.
          if (r_cnt != '0) begin
            w_cnt_d = r_cnt - 1'b1;
          end else begin
            w_md_state_d = MdIdle;
          end
        end
        default: begin
          w_md_state_d = MdIdle;
          w_cnt_d      = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_mdstall = ((r_md_state == MdIdle) && mdstartE) ||
                ((r_md_state == MdBusy) && (r_cnt != '0));
    mdbusy    = (r_md_state == MdBusy);
  end

  // --------------------------------------------------------------------------
  // Fetch discard tracker: an exception that squashes an outstanding fetch
  // leaves a reply in flight that must be dropped when it returns.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_state <= FetchIdle;
    end else begin
      r_f_state <= w_f_state_d;
    end
  end

  always_comb begin
    w_f_state_d = r_f_state;
    unique case (r_f_state)
      FetchIdle: begin
        if (exceptionM && ireq && !idata_ok) begin
          w_f_state_d = FetchDiscard;
        end
      end
      FetchDiscard: begin
        if (idata_ok) begin
          w_f_state_d = FetchIdle;
        end
      end
      default: w_f_state_d = FetchIdle;
    endcase
  end

  always_comb begin
    idiscard = (r_f_state == FetchDiscard);
    w_istall = (ireq && !idata_ok) || (r_f_state == FetchDiscard);
    w_dstall = dreq && !ddata_ok;
  end

  // --------------------------------------------------------------------------
  // Stall / flush generation
  // --------------------------------------------------------------------------
  always_comb begin
    stallM = w_dstall;
    flushW = w_dstall;
    stallE = w_dstall || w_mdstall;
    stallD = stallE || w_lu || w_br;
    stallF = stallD || w_istall;
    flushM = w_mdstall && !w_dstall;
    flushE = (w_lu || w_br) && !stallE;
    flushD = w_istall && !stallD;
    if (exceptionM) begin
      // Memory never has a request pending alongside an exception, so the
      // dstall-driven stallM/flushW are left as computed.
      stallE = 1'b0;
      stallD = 1'b0;
      stallF = w_istall;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end
  end

endmodule
